// File: rtl/dac_spi_driver.sv
// dac_spi_driver
// Latches the 16-bit offset-binary DAC word once per SAMPLE_PERIOD clocks and
// shifts it out MSB first as a 24-bit DAC8551-style SPI frame:
// 6 don't-care zeros, 2 power-down bits (00 = normal), 16 data bits.
// All outputs are registered, so nothing in i_sample reaches a pin combinationally.
// Optional feature macro: DAC_DITHER_EN (LFSR dither folded into the sample LSB).
module dac_spi_driver #(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_sample,
  output logic        o_sample_strobe,
  output logic        o_dac_cs_n,
  output logic        o_dac_sclk,
  output logic        o_dac_mosi,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int RATE_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int HALF_W = $clog2(2 * CLK_DIV);

  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(SAMPLE_PERIOD - 1);
  localparam logic [RATE_W-1:0] RATE_ONE  = RATE_W'(1);
  localparam logic [RATE_W-1:0] RATE_ZERO = RATE_W'(0);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] BIT_LAST  = HALF_W'(2 * CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_ONE  = HALF_W'(1);
  localparam logic [HALF_W-1:0] HALF_ZERO = HALF_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CS_SETUP = 2'd1,
    ST_SHIFT    = 2'd2,
    ST_CS_HOLD  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [RATE_W-1:0] rate_cnt_r;
  logic [HALF_W-1:0] half_cnt_r, half_cnt_s;
  logic [4:0]        bit_idx_r, bit_idx_s;
  logic [23:0]       frame_r, frame_s;
  logic              tick_s;
  logic              accept_s;
  logic [15:0]       sample_word_s;
  logic              cs_n_s, sclk_s, mosi_s, busy_s, strobe_s, overrun_s;

  assign tick_s   = (rate_cnt_r == RATE_LAST);
  assign accept_s = tick_s && (state_r == ST_IDLE);

`ifdef DAC_DITHER_EN
  logic [15:0] lfsr_r;

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0 (bit 0 is the output)
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Dither source advances only when a sample is actually taken
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lfsr_r <= 16'hACE1;
    end else if (accept_s) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign sample_word_s = {i_sample[15:1], i_sample[0] ^ lfsr_r[0]};
`else
  assign sample_word_s = i_sample;
`endif

  // Free-running sample-rate counter; the FSM never stalls it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rate_cnt_r <= RATE_ZERO;
    end else if (tick_s) begin
      rate_cnt_r <= RATE_ZERO;
    end else begin
      rate_cnt_r <= rate_cnt_r + RATE_ONE;
    end
  end

  // Next-state logic; pin values are computed for the next state so they register in step with it
  always_comb begin
    state_s    = state_r;
    half_cnt_s = half_cnt_r;
    bit_idx_s  = bit_idx_r;
    frame_s    = frame_r;
    cs_n_s     = 1'b1;
    sclk_s     = 1'b0;
    mosi_s     = 1'b0;
    strobe_s   = 1'b0;
    overrun_s  = o_overrun;

    // A tick that finds the FSM anywhere but IDLE is dropped and flagged
    if (tick_s) begin
      if (state_r == ST_IDLE) begin
        strobe_s = 1'b1;
      end else begin
        overrun_s = 1'b1;
      end
    end else begin
      strobe_s = 1'b0;
    end

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s    = ST_CS_SETUP;
          half_cnt_s = HALF_ZERO;
          bit_idx_s  = 5'd0;
          frame_s    = {6'b000000, 2'b00, sample_word_s};
          cs_n_s     = 1'b0;
        end else begin
          cs_n_s = 1'b1;
        end
      end

      ST_CS_SETUP: begin
        cs_n_s = 1'b0;
        if (half_cnt_r == HALF_LAST) begin
          state_s    = ST_SHIFT;
          half_cnt_s = HALF_ZERO;
          bit_idx_s  = 5'd23;
          sclk_s     = 1'b1;
          mosi_s     = frame_r[23];
        end else begin
          half_cnt_s = half_cnt_r + HALF_ONE;
        end
      end

      ST_SHIFT: begin
        cs_n_s = 1'b0;
        if (half_cnt_r == BIT_LAST) begin
          if (bit_idx_r == 5'd0) begin
            state_s    = ST_CS_HOLD;
            half_cnt_s = HALF_ZERO;
            bit_idx_s  = 5'd0;
          end else begin
            half_cnt_s = HALF_ZERO;
            bit_idx_s  = bit_idx_r - 5'd1;
            sclk_s     = 1'b1;
            mosi_s     = frame_r[bit_idx_s];
          end
        end else begin
          // High for the first CLK_DIV cycles of the bit, low for the rest;
          // data stays put across the falling edge where the DAC samples it
          half_cnt_s = half_cnt_r + HALF_ONE;
          sclk_s     = (half_cnt_r < HALF_LAST);
          mosi_s     = frame_r[bit_idx_r];
        end
      end

      ST_CS_HOLD: begin
        if (half_cnt_r == HALF_LAST) begin
          state_s    = ST_IDLE;
          half_cnt_s = HALF_ZERO;
          bit_idx_s  = 5'd0;
          cs_n_s     = 1'b1;
        end else begin
          half_cnt_s = half_cnt_r + HALF_ONE;
          cs_n_s     = 1'b0;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        half_cnt_s = HALF_ZERO;
        bit_idx_s  = 5'd0;
        cs_n_s     = 1'b1;
      end
    endcase

    busy_s = ~cs_n_s;
  end

  // State, counters, frame word and all pins; reset drops any frame in flight at once
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r         <= ST_IDLE;
      half_cnt_r      <= HALF_ZERO;
      bit_idx_r       <= 5'd0;
      frame_r         <= 24'h000000;
      o_dac_cs_n      <= 1'b1;
      o_dac_sclk      <= 1'b0;
      o_dac_mosi      <= 1'b0;
      o_busy          <= 1'b0;
      o_sample_strobe <= 1'b0;
      o_overrun       <= 1'b0;
    end else begin
      state_r         <= state_s;
      half_cnt_r      <= half_cnt_s;
      bit_idx_r       <= bit_idx_s;
      frame_r         <= frame_s;
      o_dac_cs_n      <= cs_n_s;
      o_dac_sclk      <= sclk_s;
      o_dac_mosi      <= mosi_s;
      o_busy          <= busy_s;
      o_sample_strobe <= strobe_s;
      o_overrun       <= overrun_s;
    end
  end

endmodule

// File: doc/dac_spi_driver.md
# dac_spi_driver

Serial output stage sitting directly downstream of the synth top level. It takes the 16-bit offset-binary DAC word (mixed sample top bits + 32768), latches it at a fixed sample rate derived from `i_clk`, and shifts it out as a 24-bit SPI frame to an external 16-bit voice-coil/audio DAC (DAC8551-style framing). It also provides a one-cycle sample strobe that upstream logic can use as the audio-rate tick.

## Interface
- `CLK_DIV`, default 2: `i_clk` cycles per SCLK half-period; legal range ≥1.
- `SAMPLE_PERIOD`, default 256: `i_clk` cycles between frame starts; must satisfy ≥ 50*CLK_DIV+2.
- `i_clk`  input  1  system clock; all logic on rising edge.
- `i_reset`  input  1  asynchronous, active-high reset.
- `i_sample`  input  16  offset-binary DAC word; sampled only on the strobe cycle.
- `o_sample_strobe`  output  1  one-cycle pulse on the cycle `i_sample` is latched.
- `o_dac_cs_n`  output  1  DAC chip select / SYNC, active low.
- `o_dac_sclk`  output  1  serial clock, idles low.
- `o_dac_mosi`  output  1  serial data, MSB first.
- `o_busy`  output  1  high while a frame is in progress (cs_n low).
- `o_overrun`  output  1  sticky; set when a sample tick arrives while busy.

## Operation
- Rate counter counts 0..SAMPLE_PERIOD-1, wraps; tick = counter at SAMPLE_PERIOD-1. Counter runs free, independent of FSM.
- On tick with FSM in IDLE: latch frame word {6'b0, 2'b00 (normal power-down mode), i_sample}; pulse `o_sample_strobe`; go CS_SETUP.
- On tick while not IDLE: no latch, no strobe, set `o_overrun` (cleared only by reset); current frame unaffected.
- FSM states:
  - IDLE: cs_n=1, sclk=0, mosi=0, busy=0.
  - CS_SETUP: cs_n=0, sclk=0, mosi=0; CLK_DIV cycles, then SHIFT.
  - SHIFT: 24 bits, bit index 23 down to 0. Each bit: sclk=1 for CLK_DIV cycles, then sclk=0 for CLK_DIV cycles. mosi takes the new bit on the cycle sclk rises and holds it through the falling edge (DAC samples on falling SCLK). After bit 0 low phase -> CS_HOLD.
  - CS_HOLD: cs_n=0, sclk=0, mosi=0; CLK_DIV cycles, then IDLE.
- Internal half-period counter and bit counter are reset on every state entry; no partial-bit leftovers.
- All outputs registered; no combinational path from `i_sample` to any output.

## Timing
- Reset values: cs_n=1, sclk=0, mosi=0, sample_strobe=0, busy=0, overrun=0, FSM=IDLE, rate counter=0.
- Reset asserted mid-frame: outputs go to reset values immediately (async); frame abandoned, no completion.
- First tick: cycle SAMPLE_PERIOD-1 after reset release (counter 0 on first active edge).
- Tick on cycle t: strobe high at t+1 (registered), cs_n falls at t+1, busy rises at t+1.
- First SCLK rise at t+1+CLK_DIV with mosi=bit23 in the same cycle.
- Frame length (cs_n low): 50*CLK_DIV cycles; cs_n returns high at t+1+50*CLK_DIV.
- Default params: 100 cycles low, 156 cycles idle per 256-cycle period.
- Tick coinciding with the cycle FSM returns to IDLE: treated as busy (overrun), since state update is registered.

## Configuration
- `DAC_DITHER_EN`: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances once per accepted tick. Its bit0 is XORed into the latched sample LSB. When undefined, no LFSR exists and the sample is sent unmodified. Framing and timing are identical in both cases.

## Test plan
- Defaults, `i_sample`=16'h8000 -> after reset, strobe at cycle 256; frame bits 24'h008000 on falling SCLK; cs_n low exactly 100 cycles.
- `i_sample`=16'hA5C3, CLK_DIV=1 -> 24 SCLK pulses, each high 1 / low 1; captured word 24'h00A5C3; cs_n low 50 cycles.
- `i_sample` changes every cycle during a frame -> transmitted word equals the value present on the strobe cycle only.
- SAMPLE_PERIOD=60, CLK_DIV=2 (illegal, frame 100 cycles) -> ticks during busy set `o_overrun`=1 and are skipped, no strobe. Next frame starts on the first tick in IDLE.
- Assert `i_reset` at bit 10 of a frame -> cs_n=1, sclk=0, mosi=0 without waiting for a clock edge. After release, next frame starts SAMPLE_PERIOD cycles later with correct full framing.
- With `DAC_DITHER_EN`, `i_sample`=16'h8000 for 4 frames -> LSBs equal successive LFSR bit0 values from seed 16'hACE1. Without the macro, all 4 frames are 24'h008000.
